// File: rtl/uex_irq_ctrl.sv
// Interrupt controller: latches device events into a pending register and offers one request at a time to the irq thread (IDLE/REQ/ACTIVE, no nesting).
// Define UEX_IRQ_CTRL_LEVEL_EN for level-sensitive pending (no ack clear, overflow flag tied low); default build is edge-latched.
module uex_irq_ctrl #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             active,
  output logic [N_IRQ-1:0] pending_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [ID_W-1:0]  r_irq_id;
  logic [ID_W-1:0]  w_irq_id_nxt;
  logic [ID_W-1:0]  w_low_idx;
  logic [N_IRQ-1:0] w_eligible;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic             w_any_elig;

`ifdef UEX_IRQ_CTRL_LEVEL_EN
  assign w_pending_nxt = irq_i;
  assign ovf_o         = 1'b0;
`else
  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_clr;
  logic             w_ack_take;
  logic             r_ovf;

  assign w_ack_take    = (r_state == S_REQ) && irq_ack;
  assign w_rise        = irq_i & ~r_irq_q;
  assign w_clr         = w_ack_take ? (N_IRQ'(1) << r_irq_id) : '0;
  // A rising edge overrides the ack clear on the same bit.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_q <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_irq_q <= irq_i;
      if (|(w_rise & r_pending & ~w_clr)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ovf_o = r_ovf;
`endif

  assign w_eligible = r_pending & r_mask;
  assign w_any_elig = |w_eligible;

  always_comb begin
    w_low_idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_low_idx = ID_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    case (r_state)
      S_IDLE: begin
        if (w_any_elig) begin
          w_state_nxt  = S_REQ;
          w_irq_id_nxt = w_low_idx;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (eoi) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_mask    <= '1;
      r_irq_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_irq_id  <= w_irq_id_nxt;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  assign irq_req   = (r_state == S_REQ);
  assign active    = (r_state == S_ACTIVE);
  assign irq_id    = r_irq_id;
  assign pending_o = r_pending;

endmodule

// File: doc/uex_irq_ctrl.md
UEX_IRQ_CTRL -- requirements
Module: uex_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt inputs (legal range 1..32).
REQ-002 Parameter ID_W, default 3, width of irq_id; SHALL equal max(1, clog2(N_IRQ)).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_i  input  N_IRQ  raw interrupt lines from devices.
REQ-006 mask_we  input  1  write strobe for enable mask.
REQ-007 mask_wdata  input  N_IRQ  new enable mask value (1 = enabled).
REQ-008 irq_req  output  1  interrupt request to the uex irq thread.
REQ-009 irq_id  output  ID_W  index of requested interrupt; valid while irq_req=1.
REQ-010 irq_ack  input  1  irq thread accepts request.
REQ-011 eoi  input  1  irq thread signals end of service.
REQ-012 active  output  1  an interrupt is acknowledged and not yet ended.
REQ-013 pending_o  output  N_IRQ  current pending register.
REQ-014 ovf_o  output  1  sticky flag: an interrupt event was lost.

Function
REQ-015 State machine SHALL have states IDLE, REQ, ACTIVE; one state at a time.
REQ-016 Edge mode: irq_i registered into irq_q each cycle; rising edge = irq_i & ~irq_q.
REQ-017 Rising edge on bit k sampled at cycle n SHALL set pending[k] visible at cycle n+1, regardless of mask.
REQ-018 Mask register SHALL load mask_wdata on the cycle after mask_we=1; masked bits stay pending but are not eligible.
REQ-019 IDLE: if any bit of (pending & mask) is set, the lowest eligible index SHALL be latched into irq_id and state SHALL move to REQ; irq_req=1 is visible on the following cycle.
REQ-020 Minimum latency: edge sampled at cycle n -> irq_req=1 at cycle n+2.
REQ-021 REQ: irq_req=1 and irq_id held stable until irq_ack; mask changes SHALL NOT withdraw or change the request.
REQ-022 REQ with irq_ack=1: pending[irq_id] cleared, state -> ACTIVE, irq_req=0 and active=1 next cycle.
REQ-023 ACTIVE: no new request issued (no nesting); eoi=1 -> IDLE next cycle, active=0.
REQ-024 irq_ack outside REQ and eoi outside ACTIVE SHALL be ignored.
REQ-025 Same-cycle clear (ack) and new rising edge on the same bit: set wins; pending stays 1.
REQ-026 Rising edge on bit already pending (and not cleared that cycle) SHALL set ovf_o; ovf_o clears only on reset.
REQ-027 eoi and a new eligible pending bit in the same cycle: state goes IDLE, then REQ on the next cycle (no bypass).

Reset
REQ-028 While reset=1 at a rising edge: state IDLE, pending=0, irq_q=0, mask=all ones, irq_id=0, irq_req=0, active=0, ovf_o=0.
REQ-029 Reset asserted in REQ or ACTIVE SHALL abandon the transaction with no further irq_req until new events arrive after reset.

Configuration
REQ-030 Macro UEX_IRQ_CTRL_LEVEL_EN: when defined, pending = irq_i registered each cycle (level-sensitive); the ack clear is ignored and ovf_o is tied 0.
REQ-031 Without UEX_IRQ_CTRL_LEVEL_EN, the edge-latched behaviour of REQ-016..REQ-026 applies.

Verification
REQ-032 irq_i[3] rises cycle 10 -> pending_o=0x08 at 11, irq_req=1 irq_id=3 at 12; ack at 13 -> pending_o=0, active=1 at 14; eoi at 15 -> active=0 at 16.
REQ-033 irq_i[5] and irq_i[2] rise together -> irq_id=2 served first; after eoi, irq_id=5 requested without further edges.
REQ-034 mask=0xFB, edge on bit 2 -> no irq_req, pending_o=0x04; write mask=0xFF -> irq_req with irq_id=2 two cycles after mask_we.
REQ-035 Bit 1 pulses twice before ack -> ovf_o=1 and stays 1; single service; new edge in the ack cycle leaves pending_o[1]=1.
REQ-036 Reset asserted in ACTIVE with pending_o=0x30 -> all outputs 0 and mask=0xFF next cycle; no irq_req until a new edge.
REQ-037 With UEX_IRQ_CTRL_LEVEL_EN, hold irq_i[0]=1 through ack and eoi -> irq_id=0 requested again after returning to IDLE; ovf_o remains 0.
